// File: rtl/regdump_streamer.sv
// Register-file dump streamer: on the rising edge of halted, walks registers
// 0..NREGS-1 through a spare regfile read port and emits one beat per
// valid/ready handshake, then holds done until halted falls.
module regdump_streamer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            halted_i,
  output logic [4:0]      rf_rnum_o,
  input  logic [XLEN-1:0] rf_rdata_i,
  output logic            busy_o,
  output logic            dump_valid_o,
  input  logic            dump_ready_i,
  output logic [4:0]      dump_idx_o,
  output logic [XLEN-1:0] dump_data_o,
  output logic            dump_last_o,
  output logic            done_o
);

  localparam int unsigned IW = 5;
  localparam logic [IW-1:0] LastIdx = IW'(NREGS - 1);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              halted_q;
  logic              valid_q, valid_d;
  logic [IW-1:0]     beat_idx_q, beat_idx_d;
  logic [XLEN-1:0]   beat_data_q, beat_data_d;
  logic              beat_last_q, beat_last_d;
  logic              start;

  // Only a fresh rise of halted starts a dump; it is acted on in StIdle only.
  assign start = halted_i && !halted_q;

  // Next-state: walk idx through READ/SEND pairs, holding the beat until accepted.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    beat_idx_d  = beat_idx_q;
    beat_data_d = beat_data_q;
    beat_last_d = beat_last_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          idx_d   = '0;
        end
      end
      StRead: begin
        beat_data_d = rf_rdata_i;
        beat_idx_d  = idx_q;
        beat_last_d = (idx_q == LastIdx);
        valid_d     = 1'b1;
        state_d     = StSend;
      end
      StSend: begin
        if (dump_ready_i) begin
          valid_d = 1'b0;
          if (beat_last_q) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = StRead;
          end
        end
      end
      StDone: begin
        if (!halted_i) begin
          state_d = StIdle;
          idx_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, index, halt edge detector and output beat registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      halted_q    <= 1'b0;
      valid_q     <= 1'b0;
      beat_idx_q  <= '0;
      beat_data_q <= '0;
      beat_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      halted_q    <= halted_i;
      valid_q     <= valid_d;
      beat_idx_q  <= beat_idx_d;
      beat_data_q <= beat_data_d;
      beat_last_q <= beat_last_d;
    end
  end

  // Outputs decoded from registered state so reset clears them immediately.
  always_comb begin
    rf_rnum_o    = idx_q;
    busy_o       = (state_q == StRead) || (state_q == StSend);
    done_o       = (state_q == StDone);
    dump_valid_o = valid_q;
    dump_idx_o   = beat_idx_q;
    dump_data_o  = beat_data_q;
    dump_last_o  = beat_last_q;
  end

endmodule

// File: tb/tb_regdump_streamer.sv
// Self-checking bench for regdump_streamer: scoreboard of expected beats,
// one task per scenario, NREGS=32 main instance plus an NREGS=4 instance.
module tb_regdump_streamer;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst_b;
  // NREGS=32 instance
  logic        halted, ready, busy, dump_valid, dump_last, done;
  logic [4:0]  rf_rnum, dump_idx;
  logic [31:0] rf_rdata, dump_data;
  // NREGS=4 instance
  logic        halted4, ready4, busy4, valid4, last4, done4;
  logic [4:0]  rnum4, idx4;
  logic [31:0] rdata4, data4;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Preloaded regfile: r0 = 0, r[i] = 0x1000 + i.
  assign rf_rdata = (rf_rnum == 5'd0) ? 32'h0 : 32'h1000 + {27'b0, rf_rnum};
  assign rdata4   = (rnum4 == 5'd0) ? 32'h0 : 32'h1000 + {27'b0, rnum4};

  regdump_streamer #(.XLEN(32), .NREGS(32)) u_dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .halted_i     (halted),
    .rf_rnum_o    (rf_rnum),
    .rf_rdata_i   (rf_rdata),
    .busy_o       (busy),
    .dump_valid_o (dump_valid),
    .dump_ready_i (ready),
    .dump_idx_o   (dump_idx),
    .dump_data_o  (dump_data),
    .dump_last_o  (dump_last),
    .done_o       (done)
  );

  regdump_streamer #(.XLEN(32), .NREGS(4)) u_dut4 (
    .clk          (clk),
    .rst_b        (rst_b),
    .halted_i     (halted4),
    .rf_rnum_o    (rnum4),
    .rf_rdata_i   (rdata4),
    .busy_o       (busy4),
    .dump_valid_o (valid4),
    .dump_ready_i (ready4),
    .dump_idx_o   (idx4),
    .dump_data_o  (data4),
    .dump_last_o  (last4),
    .done_o       (done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_dump(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.idx  = 5'(i);
      b.data = (i == 0) ? 32'h0 : 32'h1000 + 32'(i);
      b.last = (i == n - 1);
      sb.push_back(b);
    end
  endtask

  task automatic test_reset();
    logic seen_valid = 1'b0;
    rst_b = 1'b0; halted = 1'b0; ready = 1'b0; halted4 = 1'b0; ready4 = 1'b1;
    #3;
    n_checks++;
    if ({dump_valid, busy, done, rf_rnum, dump_idx, dump_data, dump_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b busy=%b done=%b rnum=%0d idx=%0d data=%h last=%b, want all 0",
               dump_valid, busy, done, rf_rnum, dump_idx, dump_data, dump_last);
    end
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk); halted = 1'b1;
    for (int c = 0; c < 10 && !seen_valid; c++) begin
      @(negedge clk);
      seen_valid = dump_valid;
    end
    n_checks++;
    if (!seen_valid) begin
      n_fail++;
      $display("FAIL reset_reach_send: got valid=0, want valid=1 within 10 cycles");
    end
    #2 rst_b = 1'b0;
    #1;
    n_checks++;
    if ({dump_valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_send: got valid=%b busy=%b done=%b, want 0 0 0",
               dump_valid, busy, done);
    end
    @(negedge clk); halted = 1'b0; rst_b = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({dump_valid, busy, done, rf_rnum} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle_after: got valid=%b busy=%b done=%b rnum=%0d, want 0 0 0 0",
               dump_valid, busy, done, rf_rnum);
    end
  endtask

  task automatic test_full_dump();
    beat_t exp;
    int    first_valid = 0;
    int    done_cyc = 0;
    push_dump(32);
    @(negedge clk); halted = 1'b1; ready = 1'b1;
    for (int c = 1; c <= 200 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (dump_valid && first_valid == 0) first_valid = c;
      if (dump_valid && ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL full_extra_beat: got idx=%0d, want no beat", dump_idx);
        end else begin
          exp = sb.pop_front();
          if ({dump_idx, dump_data, dump_last} !== {exp.idx, exp.data, exp.last}) begin
            n_fail++;
            $display("FAIL full_beat: got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                     dump_idx, dump_data, dump_last, exp.idx, exp.data, exp.last);
          end
        end
      end
      if (done) done_cyc = c;
    end
    n_checks++;
    if (first_valid != 2) begin
      n_fail++;
      $display("FAIL full_first_valid: got cycle %0d, want 2", first_valid);
    end
    n_checks++;
    if (done_cyc != 65 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL full_done: got done cycle %0d with %0d beats missing, want cycle 65 and 0",
               done_cyc, sb.size());
    end
    sb.delete();
    @(negedge clk); halted = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL full_exit_done: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    beat_t exp;
    logic        stalled = 1'b0;
    logic        seen_done = 1'b0;
    logic [4:0]  h_idx;
    logic [31:0] h_data;
    logic        h_last;
    push_dump(32);
    @(negedge clk); halted = 1'b1; ready = 1'b1;
    for (int c = 1; c <= 400 && !seen_done; c++) begin
      @(negedge clk);
      if (dump_valid && dump_idx == 5'd3 && !stalled) begin
        stalled = 1'b1; ready = 1'b0;
        h_idx = dump_idx; h_data = dump_data; h_last = dump_last;
        repeat (5) begin
          @(negedge clk);
          n_checks++;
          if (dump_valid !== 1'b1 || dump_idx !== h_idx || dump_data !== h_data
              || dump_last !== h_last) begin
            n_fail++;
            $display("FAIL bp_hold: got valid=%b idx=%0d data=%h last=%b, want valid=1 idx=%0d data=%h last=%b",
                     dump_valid, dump_idx, dump_data, dump_last, h_idx, h_data, h_last);
          end
        end
        ready = 1'b1;
      end
      if (dump_valid && ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra_beat: got idx=%0d, want no beat", dump_idx);
        end else begin
          exp = sb.pop_front();
          if ({dump_idx, dump_data, dump_last} !== {exp.idx, exp.data, exp.last}) begin
            n_fail++;
            $display("FAIL bp_beat: got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                     dump_idx, dump_data, dump_last, exp.idx, exp.data, exp.last);
          end
        end
      end
      if (done) seen_done = 1'b1;
    end
    n_checks++;
    if (!seen_done || !stalled || sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_complete: got done=%b stalled=%b missing=%0d, want 1 1 0",
               seen_done, stalled, sb.size());
    end
    sb.delete();
    @(negedge clk); halted = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_halt_drop();
    beat_t exp;
    logic seen_done;
    for (int pass = 0; pass < 2; pass++) begin
      seen_done = 1'b0;
      push_dump(32);
      @(negedge clk); halted = 1'b1; ready = 1'b1;
      for (int c = 1; c <= 200 && !seen_done; c++) begin
        @(negedge clk);
        if (dump_valid && ready) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL drop_extra_beat: got idx=%0d, want no beat", dump_idx);
          end else begin
            exp = sb.pop_front();
            if ({dump_idx, dump_data, dump_last} !== {exp.idx, exp.data, exp.last}) begin
              n_fail++;
              $display("FAIL drop_beat: pass %0d got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                       pass, dump_idx, dump_data, dump_last, exp.idx, exp.data, exp.last);
            end
            if (pass == 0 && exp.idx == 5'd10) halted = 1'b0;
          end
        end
        if (done) seen_done = 1'b1;
      end
      n_checks++;
      if (!seen_done || sb.size() != 0) begin
        n_fail++;
        $display("FAIL drop_complete: pass %0d got done=%b missing=%0d, want 1 0",
                 pass, seen_done, sb.size());
      end
      sb.delete();
      halted = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({done, busy, rf_rnum} !== '0) begin
        n_fail++;
        $display("FAIL drop_done_pulse: pass %0d got done=%b busy=%b rnum=%0d, want 0 0 0",
                 pass, done, busy, rf_rnum);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_rnum();
    @(negedge clk); halted = 1'b1; ready = 1'b1;
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== (c <= 64) || dump_valid !== (c <= 64 && c % 2 == 0) || done !== (c == 65)) begin
        n_fail++;
        $display("FAIL busy_phase: cycle %0d got busy=%b valid=%b done=%b, want %b %b %b",
                 c, busy, dump_valid, done, (c <= 64), (c <= 64 && c % 2 == 0), (c == 65));
      end
      if (c % 2 == 1 && c <= 63) begin
        n_checks++;
        if (rf_rnum !== 5'((c - 1) / 2)) begin
          n_fail++;
          $display("FAIL read_rnum: cycle %0d got rnum=%0d, want %0d", c, rf_rnum, (c - 1) / 2);
        end
      end
    end
    halted = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nregs4();
    beat_t exp;
    int    done_cyc = 0;
    @(negedge clk); rst_b = 1'b0; halted4 = 1'b1; ready4 = 1'b1;
    push_dump(4);
    @(negedge clk); rst_b = 1'b1;
    for (int c = 1; c <= 50 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (valid4 && ready4) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL n4_extra_beat: got idx=%0d, want no beat", idx4);
        end else begin
          exp = sb.pop_front();
          if ({idx4, data4, last4} !== {exp.idx, exp.data, exp.last}) begin
            n_fail++;
            $display("FAIL n4_beat: got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                     idx4, data4, last4, exp.idx, exp.data, exp.last);
          end
        end
      end
      if (done4) done_cyc = c;
    end
    n_checks++;
    if (done_cyc != 9 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL n4_done: got done cycle %0d missing=%0d, want 9 and 0", done_cyc, sb.size());
    end
    sb.delete();
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if ({done4, busy4, valid4} !== 3'b100) begin
        n_fail++;
        $display("FAIL n4_done_hold: got done=%b busy=%b valid=%b, want 1 0 0", done4, busy4, valid4);
      end
    end
    halted4 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done4 !== 1'b0) begin
      n_fail++;
      $display("FAIL n4_done_clear: got done=%b, want 0", done4);
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_halt_drop();
    test_busy_rnum();
    test_nregs4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
